// File: rtl/axi_pkg.sv
// Shared AXI encodings and the line-fill FSM state type.
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] ARCACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] ARPROT_DEFAULT  = 3'b000;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} line_fill_state_e;
endpackage

// File: rtl/axi_interface_if.sv
// AXI4 read-channel bundle (AR + R) with master and slave views.
interface axi_interface_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int ID_W   = 8,
  parameter int USER_W = 1
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic [USER_W-1:0] aruser;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport rd_mst (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport rd_slv (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_line_fill_rd_mst.sv
// Cache line-fill AXI4 read master: one request -> one burst -> one assembled line.
// AXI_LINE_FILL_WRAP_BURST_EN selects a critical-beat-first WRAP burst instead of INCR.
module axi_line_fill_rd_mst
  import axi_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int ID_W       = 8,
  parameter int LINE_BYTES = 64,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [LINE_BYTES*8-1:0] resp_data,
  output logic                    resp_err,
  axi_interface_if.rd_mst         m_axi
);
  localparam int BEATS  = LINE_BYTES * 8 / DATA_W;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int SZ_W   = $clog2(DATA_W / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ID_W-1:0]   ARID      = ID_W'(AXI_ID);

  line_fill_state_e r_state, w_nxt;
  logic r_req_ready, r_arvalid, r_rready, r_resp_valid, r_err;
  logic [ADDR_W-1:0] r_araddr, w_araddr;
  logic [BEAT_W-1:0] r_cnt, w_lane;
  logic [BEATS-1:0][DATA_W-1:0] r_data;
  logic w_req_hs, w_beat, w_last_beat, w_beat_err;

  assign w_req_hs    = req_valid & r_req_ready;
  assign w_beat      = m_axi.rvalid & r_rready;
  assign w_last_beat = (r_cnt == LAST_BEAT);
  assign w_beat_err  = (m_axi.rresp != RESP_OKAY) | (m_axi.rid != ARID);

`ifdef AXI_LINE_FILL_WRAP_BURST_EN
  logic [BEAT_W-1:0] r_start;
  // Slave returns the critical beat first; rotate it back into line order.
  assign w_araddr = req_addr & ~ADDR_W'(DATA_W / 8 - 1);
  assign w_lane   = r_cnt + r_start;
  always_ff @(posedge clk) begin
    if (rst)           r_start <= '0;
    else if (w_req_hs) r_start <= req_addr[OFF_W-1:SZ_W];
  end
`else
  assign w_araddr = req_addr & ~ADDR_W'(LINE_BYTES - 1);
  assign w_lane   = r_cnt;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_req_hs) w_nxt = ADDR;
      ADDR:    if (m_axi.arready) w_nxt = DATA;
      DATA:    if (w_beat && (m_axi.rlast || w_last_beat)) w_nxt = RESP;
      RESP:    if (resp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_req_ready  <= (w_nxt == IDLE);
      r_arvalid    <= (w_nxt == ADDR);
      r_rready     <= (w_nxt == DATA);
      r_resp_valid <= (w_nxt == RESP);
    end
  end

  // Lanes are cleared per request so a short (early-rlast) burst leaves zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_data   <= '0;
    end else if (w_req_hs) begin
      r_araddr <= w_araddr;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_data   <= '0;
    end else if (w_beat) begin
      r_data[w_lane] <= m_axi.rdata;
      if (!w_last_beat) r_cnt <= r_cnt + 1'b1;
      if (w_beat_err || (m_axi.rlast != w_last_beat)) r_err <= 1'b1;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_data;
  assign resp_err   = r_err;

  assign m_axi.arvalid  = r_arvalid;
  assign m_axi.araddr   = r_araddr;
  assign m_axi.arid     = ARID;
  assign m_axi.arlen    = 8'(BEATS - 1);
  assign m_axi.arsize   = 3'(SZ_W);
`ifdef AXI_LINE_FILL_WRAP_BURST_EN
  assign m_axi.arburst  = BURST_WRAP;
`else
  assign m_axi.arburst  = BURST_INCR;
`endif
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = ARCACHE_DEFAULT;
  assign m_axi.arprot   = ARPROT_DEFAULT;
  assign m_axi.arqos    = '0;
  assign m_axi.arregion = '0;
  assign m_axi.aruser   = '0;
  assign m_axi.rready   = r_rready;
endmodule

// File: tb/tb_axi_line_fill_rd_mst.sv
// Self-checking bench for axi_line_fill_rd_mst: scripted AXI slave plus a line-level model.
module tb_axi_line_fill_rd_mst;
  localparam int BEATS = 8;
  localparam int LW    = 512;
`ifdef AXI_LINE_FILL_WRAP_BURST_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_err;
  logic [63:0] req_addr = '0;
  logic [LW-1:0] resp_data;

  axi_interface_if #(.DATA_W(64), .ADDR_W(64), .ID_W(8)) axi ();

  axi_line_fill_rd_mst #(.DATA_W(64), .ADDR_W(64), .ID_W(8), .LINE_BYTES(64), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .m_axi(axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  bit busy = 1'b0, model_ready = 1'b0;
  logic [63:0] exp_araddr;
  logic [1:0]  exp_burst;
  int          exp_start;
  logic [LW-1:0] exp_data, cap_data;
  logic        exp_err, cap_err;
  logic [63:0] cap_araddr;
  logic [7:0]  cap_arlen, cap_arid;
  logic [2:0]  cap_arsize;
  logic [1:0]  cap_arburst;

  int cfg_ar_wait, cfg_resp_wait, cfg_err_beat, cfg_bad_id_beat, cfg_early, cfg_abort_after;
  bit cfg_nolast;
  logic [1:0] cfg_err_resp;
  int cfg_gap[BEATS];
  logic [63:0] beat_d[BEATS];
  logic [1:0]  sent_resp[BEATS];
  logic [7:0]  sent_id[BEATS];
  logic        sent_last[BEATS];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    cfg_ar_wait = 0; cfg_resp_wait = 0; cfg_err_beat = -1; cfg_err_resp = 2'b00;
    cfg_bad_id_beat = -1; cfg_early = -1; cfg_nolast = 1'b0; cfg_abort_after = -1;
    for (int k = 0; k < BEATS; k++) begin
      cfg_gap[k] = 0;
      beat_d[k]  = {$urandom, $urandom};
    end
  endtask

  task automatic request(input logic [63:0] addr);
    int w;
    exp_araddr  = WRAP ? (addr & ~64'h7) : (addr & ~64'h3F);
    exp_burst   = WRAP ? 2'b10 : 2'b01;
    exp_start   = WRAP ? int'(addr[5:3]) : 0;
    model_ready = 1'b0;
    req_addr    = addr;
    req_valid   = 1'b1;
    w = 0;
    while (!req_ready) begin
      tick();
      if (++w > 50) abort_run("req_ready_wait");
    end
    tick();
    req_valid = 1'b0;
    busy      = 1'b1;
  endtask

  task automatic slave_burst(output bit aborted);
    int w, nb;
    aborted = 1'b0;
    w = 0;
    while (!axi.arvalid) begin
      tick();
      if (++w > 50) abort_run("arvalid_wait");
    end
    repeat (cfg_ar_wait) tick();
    cap_araddr = axi.araddr; cap_arlen = axi.arlen; cap_arsize = axi.arsize;
    cap_arburst = axi.arburst; cap_arid = axi.arid;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    nb = (cfg_early >= 0) ? cfg_early + 1 : BEATS;
    for (int k = 0; k < nb; k++) begin
      axi.rvalid = 1'b0;
      repeat (cfg_gap[k]) tick();
      sent_resp[k] = (k == cfg_err_beat) ? cfg_err_resp : 2'b00;
      sent_id[k]   = (k == cfg_bad_id_beat) ? 8'h5A : 8'h00;
      sent_last[k] = (k == cfg_early) || (k == BEATS - 1 && !cfg_nolast);
      axi.rvalid = 1'b1; axi.rdata = beat_d[k]; axi.rresp = sent_resp[k];
      axi.rid = sent_id[k]; axi.rlast = sent_last[k];
      w = 0;
      while (!axi.rready) begin
        tick();
        if (++w > 50) abort_run("rready_wait");
      end
      tick();
      if (k == cfg_abort_after) begin
        axi.rvalid = 1'b0;
        aborted = 1'b1;
        return;
      end
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    // Line-level expectation: beats land in rotated lane order, anything bad is sticky.
    exp_data = '0;
    exp_err  = (nb < BEATS) || !sent_last[BEATS-1];
    for (int k = 0; k < nb; k++) begin
      exp_data[((exp_start + k) % BEATS) * 64 +: 64] = beat_d[k];
      if (sent_resp[k] != 2'b00 || sent_id[k] != 8'h00) exp_err = 1'b1;
    end
    model_ready = 1'b1;
  endtask

  task automatic consume();
    check("resp_latency", LW'(resp_valid), LW'(1));
    repeat (cfg_resp_wait) tick();
    cap_data = resp_data;
    cap_err  = resp_err;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    busy = 1'b0;
    check("req_ready_after_hs", LW'(req_ready), LW'(1));
    check("resp_valid_drop", LW'(resp_valid), '0);
  endtask

  task automatic run_txn(input logic [63:0] addr);
    bit ab;
    request(addr);
    slave_burst(ab);
    if (ab) begin
      rst = 1'b1;
      tick();
      check("rst_outputs", LW'({axi.arvalid, axi.rready, resp_valid, req_ready, resp_err}), '0);
      check("rst_data", resp_data, '0);
      rst  = 1'b0;
      busy = 1'b0;
      tick();
      check("rst_req_ready", LW'(req_ready), LW'(1));
    end else begin
      consume();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!busy) check("idle_quiet", LW'({axi.arvalid, axi.rready, resp_valid}), '0);
      else       check("busy_req_ready", LW'(req_ready), '0);
      if (axi.arvalid)
        check("ar_fields",
              LW'({axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid, axi.arlock,
                   axi.arcache, axi.arprot, axi.arqos, axi.arregion}),
              LW'({exp_araddr, 8'd7, 3'd3, exp_burst, 8'd0, 1'b0, 4'b0011, 3'b000, 4'd0, 4'd0}));
      if (resp_valid) begin
        check("resp_after_beats", LW'(model_ready), LW'(1));
        if (model_ready) begin
          check("resp_data", resp_data, exp_data);
          check("resp_err", LW'(resp_err), LW'(exp_err));
        end
      end
    end
  end

  initial begin
    #200000;
    abort_run("global_watchdog");
  end

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rid = '0; axi.rlast = 1'b0;
    clear_cfg();
    repeat (3) tick();
    check("reset_ctrl", LW'({req_ready, axi.arvalid, axi.rready, resp_valid, resp_err}), '0);
    check("reset_data", resp_data, '0);
    rst = 1'b0;
    tick();
    check("req_ready_after_reset", LW'(req_ready), LW'(1));

    // Basic fill with the fixed pattern
    clear_cfg();
    for (int k = 0; k < BEATS; k++) beat_d[k] = 64'h1111_1111_1111_1111 * (k + 1);
    run_txn(64'h1000_0028);
    check("basic_araddr", LW'(cap_araddr), WRAP ? LW'(64'h1000_0028) : LW'(64'h1000_0000));
    check("basic_arlen_size_id", LW'({cap_arlen, cap_arsize, cap_arid}), LW'({8'd7, 3'd3, 8'd0}));
    check("basic_arburst", LW'(cap_arburst), WRAP ? LW'(2'b10) : LW'(2'b01));
    check("basic_lane3", LW'(cap_data[3*64 +: 64]),
          WRAP ? LW'(64'h7777_7777_7777_7777) : LW'(64'h4444_4444_4444_4444));
    check("basic_lane7", LW'(cap_data[7*64 +: 64]),
          WRAP ? LW'(64'h3333_3333_3333_3333) : LW'(64'h8888_8888_8888_8888));
    check("basic_err", LW'(cap_err), '0);

    // Backpressure on AR, R gaps, delayed consumer
    clear_cfg();
    cfg_ar_wait = 5; cfg_gap[3] = 2; cfg_gap[6] = 3; cfg_resp_wait = 4;
    run_txn(64'h0000_4000_0000_0010);

    // SLVERR on beat 3, then a clean request clears the error
    clear_cfg();
    cfg_err_beat = 3; cfg_err_resp = 2'b10;
    run_txn(64'h1000_0100);
    check("slverr_err", LW'(cap_err), LW'(1));
    clear_cfg();
    run_txn(64'h1000_0140);
    check("clean_after_err", LW'(cap_err), '0);

    // Early rlast on beat 5 (aligned address so lane order is identity in either mode)
    clear_cfg();
    cfg_early = 5;
    run_txn(64'h3000_0000);
    check("early_hi_lanes_zero", LW'(cap_data[6*64 +: 128]), '0);
    check("early_err", LW'(cap_err), LW'(1));
    clear_cfg();
    cfg_nolast = 1'b1;
    run_txn(64'h3000_0040);
    check("nolast_err", LW'(cap_err), LW'(1));

    // Reset in the middle of the data phase, then recover
    clear_cfg();
    cfg_abort_after = 4;
    run_txn(64'h5000_0000);
    clear_cfg();
    run_txn(64'h5000_0080);
    check("post_reset_err", LW'(cap_err), '0);

`ifdef AXI_LINE_FILL_WRAP_BURST_EN
    clear_cfg();
    run_txn(64'h2000_0030);
    check("wrap_araddr", LW'(cap_araddr), LW'(64'h2000_0030));
    check("wrap_arburst", LW'(cap_arburst), LW'(2'b10));
    check("wrap_beat0_lane6", LW'(cap_data[6*64 +: 64]), LW'(beat_d[0]));
    check("wrap_beat2_lane0", LW'(cap_data[0 +: 64]), LW'(beat_d[2]));
`endif

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      clear_cfg();
      cfg_ar_wait   = $urandom_range(0, 3);
      cfg_resp_wait = $urandom_range(0, 3);
      for (int k = 0; k < BEATS; k++) cfg_gap[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if ($urandom_range(0, 4) == 0) begin
        cfg_err_beat = $urandom_range(0, BEATS - 1);
        cfg_err_resp = 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 7) == 0) cfg_bad_id_beat = $urandom_range(0, BEATS - 1);
      if ($urandom_range(0, 7) == 0) cfg_early = $urandom_range(0, BEATS - 2);
      else if ($urandom_range(0, 9) == 0) cfg_nolast = 1'b1;
      run_txn({$urandom, $urandom});
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi_line_fill_rd_mst.md
Name: axi_line_fill_rd_mst

Overview:
- AXI4 read master that turns one cache line-fill request into a single INCR burst on the `rd_mst` modport of `axi_interface_if`.
- Assembles the returned beats into one line and hands it upstream to the cache controller.
- At most one burst outstanding.
- Sits directly between the L1 refill logic and the memory-side AXI fabric/slave.

Parameters:
- DATA_W, 64, AXI data width in bits; must equal the interface DATA_W.
- ADDR_W, 64, AXI/request address width.
- ID_W, 8, AXI ID width.
- LINE_BYTES, 64, cache line size in bytes; power of two, ≥ DATA_W/8.
- AXI_ID, 0, constant ARID driven on every burst.
- Derived: BEATS = LINE_BYTES*8/DATA_W; OFF_W = log2(LINE_BYTES); BEAT_W = max(1, log2(BEATS)).

Ports:
- clk  input  1  clock, all logic rising-edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  line-fill request valid
- req_ready  output  1  request accepted when valid&ready
- req_addr  input  ADDR_W  any byte address inside the target line
- resp_valid  output  1  filled line available
- resp_ready  input  1  consumer accepts line
- resp_data  output  LINE_BYTES*8  line data; beat i in bits [i*DATA_W +: DATA_W]
- resp_err  output  1  any SLVERR/DECERR, RID mismatch or RLAST framing error
- m_axi  interface  -  `axi_interface_if.rd_mst`

Behaviour:
- Clock and reset are fixed: one clock `clk`; `rst` is synchronous and active-high.
- Reset values: req_ready=0, arvalid=0, rready=0, resp_valid=0, resp_err=0, resp_data=0, state=IDLE, beat counter=0.
- FSM states: IDLE → ADDR → DATA → RESP → IDLE.
- IDLE:
  - req_ready=1 (registered, asserted the cycle after reset deasserts).
  - On req_valid&req_ready: latch req_addr with bits [OFF_W-1:0] cleared, clear err and counter, go to ADDR.
- ADDR:
  - arvalid=1; all AR fields are registered and stable until arready.
  - araddr = aligned address; arlen = BEATS-1; arsize = log2(DATA_W/8); arburst = 2'b01 (INCR); arid = AXI_ID.
  - arlock=0, arcache=4'b0011, arprot=3'b000, arqos=0, arregion=0, aruser=0.
  - On arready: go to DATA.
- DATA:
  - rready=1; each rvalid beat is written to lane `cnt`, then cnt increments.
  - rresp≠2'b00 or rid≠AXI_ID sets a sticky err; the beat is still stored.
  - rlast on beat cnt<BEATS-1: err=1, unwritten lanes stay 0, go to RESP.
  - Beat BEATS-1 always ends DATA and goes to RESP; if its rlast=0, err=1.
- RESP:
  - resp_valid=1; resp_data and resp_err are held stable until resp_ready.
  - On handshake go to IDLE; req_ready rises the next cycle, so a new request cannot be accepted in the handshake cycle.
- Minimum latency with zero-wait slave: request accepted at cycle 0 → arvalid cycle 1 → first beat accepted cycle 2 at the earliest → resp_valid the cycle after the last beat accepted.
- AR and R outside the states above: arvalid=0, rready=0.
- rvalid arriving in IDLE/ADDR/RESP is not accepted (rready=0).
- rst mid-burst: all state and outputs go to reset values the next edge. The outstanding AXI burst is abandoned; reset is system-global, so the slave resets too.
- Counter wrap: cnt is BEAT_W bits and never increments past BEATS-1.

Optional Feature:
- Macro: AXI_LINE_FILL_WRAP_BURST_EN.
- Defined:
  - araddr keeps the DATA_W-aligned critical-beat address (bits below log2(DATA_W/8) cleared); arburst = 2'b10 (WRAP).
  - Beat k is stored in lane (start_beat + k) mod BEATS, where start_beat = req_addr[OFF_W-1:log2(DATA_W/8)].
  - resp_data layout is identical to INCR mode.
  - BEATS must be 2, 4, 8 or 16.
- Undefined: INCR from the line-aligned address as above.

Decomposition:
- Shared package `axi_pkg`:
  - burst constants BURST_FIXED/INCR/WRAP;
  - resp constants RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - default ARCACHE/ARPROT constants;
  - `line_fill_state_e` enum (IDLE, ADDR, DATA, RESP).
- No sub-module; lane assembly and FSM fit in one module.

Test Plan (LINE_BYTES=64, DATA_W=64 → 8 beats):
- Basic fill: req_addr 0x1000_0028, beat i data = 64'h1111_1111_1111_1111*(i+1), zero-wait slave → araddr 0x1000_0000, arlen 7, arsize 3, arburst 01, arid 0; 8 beats; resp_data lane i correct; resp_err 0.
- Backpressure: arready low 5 cycles, rvalid gaps after beats 2 and 5, resp_ready low 4 cycles → AR fields stable while arvalid=1, beat order preserved, resp_data stable, req_ready 0 until the cycle after the handshake.
- Error: rresp=2'b10 on beat 3 → all 8 beats consumed, resp_err=1; next clean request → resp_err=0.
- Framing: rlast on beat 5 → RESP entered, lanes 6–7 zero, resp_err=1. Separately, rlast=0 on beat 7 → resp_err=1 after 8 beats.
- Reset mid-DATA: rst high for 1 cycle after beat 4 → arvalid/rready/resp_valid=0 next cycle, req_ready=1 the cycle after rst deasserts.
- WRAP (macro defined): req_addr 0x2000_0030 → araddr 0x2000_0030, arburst 10; beat 0 lands in lane 6, beat 2 in lane 0.
